// File: rtl/nurn_update_seq.sv
// nurn_update_seq: per-timestep sweep reading each neuron's state, integrating current, firing and writing back.
// Define NURN_LEAK_EN to add a shift-based membrane leak (LEAK_SHIFT).
module nurn_update_seq #(
    parameter int NUM_NURNS          = 256,
    parameter int DSIZE              = 16,
    parameter int NURN_CNT_BIT_WIDTH = 8,
`ifdef NURN_LEAK_EN
    parameter int LEAK_SHIFT         = 4,
`endif
    parameter int STDP_WIN_BIT_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          stat_rd_en_o,
    output logic [NURN_CNT_BIT_WIDTH+1:0] stat_rd_addr_o,
    input  logic [DSIZE-1:0]              stat_rd_data_i,
    output logic                          stat_wr_en_o,
    output logic [NURN_CNT_BIT_WIDTH+1:0] stat_wr_addr_o,
    output logic [DSIZE-1:0]              stat_wr_data_o,
    output logic                          curr_rd_en_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0] curr_addr_o,
    input  logic [DSIZE-1:0]              curr_data_i,
    output logic                          spike_vld_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0] spike_nurn_o
);
    localparam int NW = NURN_CNT_BIT_WIDTH;
    localparam int AW = NW + 2;
    localparam int HW = STDP_WIN_BIT_WIDTH;
    localparam int SW = DSIZE + 2;
    localparam logic [NW-1:0] LAST = NW'(NUM_NURNS - 1);
    localparam logic signed [SW-1:0] SMAX = {3'b000, {(DSIZE-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {3'b111, {(DSIZE-1){1'b0}}};

    typedef enum logic [3:0] {IDLE, RB, RP, RT, RH, CAP, CALC, WP, WH, DONE} state_e;

    state_e                  state_q, state_d;
    logic [NW-1:0]           n_q, n_d;
    logic signed [DSIZE-1:0] bias_q, bias_d, curr_q, curr_d, pot_q, pot_d, th_q, th_d, sum_q, sum_d;
    logic [HW-1:0]           hist_q, hist_d, hist_inc;
    logic                    spike_q, spike_d;
    logic signed [SW-1:0]    sum_w;
    logic signed [DSIZE-1:0] sat_w;
    logic                    busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic                    curr_en_q, curr_en_d, spk_q, spk_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DSIZE-1:0]        wr_data_q, wr_data_d;
    logic [NW-1:0]           curr_addr_q, curr_addr_d, spk_n_q, spk_n_d;

    // Two guard bits hold the three-term sum before saturation.
`ifdef NURN_LEAK_EN
    assign sum_w = SW'(pot_q) - SW'(pot_q >>> LEAK_SHIFT) + SW'(bias_q) + SW'(curr_q);
`else
    assign sum_w = SW'(pot_q) + SW'(bias_q) + SW'(curr_q);
`endif
    assign sat_w    = (sum_w > SMAX) ? DSIZE'(SMAX) : (sum_w < SMIN) ? DSIZE'(SMIN) : sum_w[DSIZE-1:0];
    assign hist_inc = &hist_q ? hist_q : hist_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        bias_d      = bias_q;
        curr_d      = curr_q;
        pot_d       = pot_q;
        th_d        = th_q;
        hist_d      = hist_q;
        sum_d       = sum_q;
        spike_d     = spike_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        curr_en_d   = 1'b0;
        spk_d       = 1'b0;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        curr_addr_d = curr_addr_q;
        spk_n_d     = spk_n_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RB;
                n_d     = '0;
            end
            RB:   state_d = RP;
            RP: begin
                bias_d  = stat_rd_data_i;
                curr_d  = curr_data_i;
                state_d = RT;
            end
            RT: begin
                pot_d   = stat_rd_data_i;
                state_d = RH;
            end
            RH: begin
                th_d    = stat_rd_data_i;
                state_d = CAP;
            end
            CAP: begin
                hist_d  = stat_rd_data_i[HW-1:0];
                state_d = CALC;
            end
            CALC: begin
                sum_d   = sat_w;
                spike_d = sat_w >= th_q;
                state_d = WP;
            end
            WP:   state_d = WH;
            WH: if (n_q == LAST) state_d = DONE;
                else begin
                    state_d = RB;
                    n_d     = n_q + 1'b1;
                end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = state_d == DONE;
        case (state_d)
            RB, RP, RT, RH: begin
                rd_en_d   = 1'b1;
                rd_addr_d = {n_d, state_d == RB ? 2'b00 : state_d == RP ? 2'b01 : state_d == RT ? 2'b10 : 2'b11};
                if (state_d == RB) begin
                    curr_en_d   = 1'b1;
                    curr_addr_d = n_d;
                end
            end
            WP: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {n_d, 2'b01};
                wr_data_d = spike_d ? '0 : sum_d;
                spk_d     = spike_d;
                spk_n_d   = n_d;
            end
            WH: begin
                wr_en_d   = 1'b1;
                wr_addr_d = {n_d, 2'b11};
                wr_data_d = spike_d ? '0 : DSIZE'(hist_inc);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            n_q         <= '0;
            bias_q      <= '0;
            curr_q      <= '0;
            pot_q       <= '0;
            th_q        <= '0;
            hist_q      <= '0;
            sum_q       <= '0;
            spike_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            curr_en_q   <= 1'b0;
            spk_q       <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            curr_addr_q <= '0;
            spk_n_q     <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            bias_q      <= bias_d;
            curr_q      <= curr_d;
            pot_q       <= pot_d;
            th_q        <= th_d;
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            spike_q     <= spike_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            curr_en_q   <= curr_en_d;
            spk_q       <= spk_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            curr_addr_q <= curr_addr_d;
            spk_n_q     <= spk_n_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign stat_rd_en_o   = rd_en_q;
    assign stat_rd_addr_o = rd_addr_q;
    assign stat_wr_en_o   = wr_en_q;
    assign stat_wr_addr_o = wr_addr_q;
    assign stat_wr_data_o = wr_data_q;
    assign curr_rd_en_o   = curr_en_q;
    assign curr_addr_o    = curr_addr_q;
    assign spike_vld_o    = spk_q;
    assign spike_nurn_o   = spk_n_q;
endmodule

// File: tb/tb_nurn_update_seq.sv
// tb_nurn_update_seq: status/current memory model with a write/spike scoreboard for a 4-neuron sweep.
`timescale 1ns/1ps
module tb_nurn_update_seq;
    localparam int N  = 4;
    localparam int D  = 16;
    localparam int NW = 2;
    localparam int AW = NW + 2;
    localparam int HW = 8;
`ifdef NURN_LEAK_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    logic          clk_i = 1'b0, rst_n_i = 1'b0, start_i = 1'b0;
    logic          busy_o, done_o, stat_rd_en_o, stat_wr_en_o, curr_rd_en_o, spike_vld_o;
    logic [AW-1:0] stat_rd_addr_o, stat_wr_addr_o;
    logic [D-1:0]  stat_rd_data_i, stat_wr_data_o, curr_data_i;
    logic [NW-1:0] curr_addr_o, spike_nurn_o;

    logic [D-1:0]      mem [16];
    logic [D-1:0]      init_mem [16];
    logic [D-1:0]      post [16];
    logic [D-1:0]      curr [N];
    logic              load = 1'b0;
    logic [AW+D-1:0]   exp_wr [$];
    logic [NW-1:0]     exp_spk [$];
    int errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0;

    nurn_update_seq #(
        .NUM_NURNS(N), .DSIZE(D), .NURN_CNT_BIT_WIDTH(NW), .STDP_WIN_BIT_WIDTH(HW)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .stat_rd_en_o(stat_rd_en_o), .stat_rd_addr_o(stat_rd_addr_o), .stat_rd_data_i(stat_rd_data_i),
        .stat_wr_en_o(stat_wr_en_o), .stat_wr_addr_o(stat_wr_addr_o), .stat_wr_data_o(stat_wr_data_o),
        .curr_rd_en_o(curr_rd_en_o), .curr_addr_o(curr_addr_o), .curr_data_i(curr_data_i),
        .spike_vld_o(spike_vld_o), .spike_nurn_o(spike_nurn_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        if (load) mem <= init_mem;
        else if (stat_wr_en_o) mem[stat_wr_addr_o] <= stat_wr_data_o;
        if (stat_rd_en_o) stat_rd_data_i <= mem[stat_rd_addr_o];
        if (curr_rd_en_o) curr_data_i <= curr[curr_addr_o];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string name);
        chk({name, "_en"}, {busy_o, done_o, stat_rd_en_o, stat_wr_en_o, curr_rd_en_o, spike_vld_o}, 0);
        chk({name, "_bus"}, {stat_rd_addr_o, stat_wr_addr_o, stat_wr_data_o, curr_addr_o, spike_nurn_o}, 0);
    endtask

    task automatic set_n(input int n, input logic [D-1:0] b, p, t, h, c);
        init_mem[4*n]   = b;
        init_mem[4*n+1] = p;
        init_mem[4*n+2] = t;
        init_mem[4*n+3] = h;
        curr[n]         = c;
    endtask

    task automatic do_load();
        @(negedge clk_i);
        load = 1'b1;
        @(negedge clk_i);
        load = 1'b0;
    endtask

    task automatic exp_n(input int n, input logic [D-1:0] pot, input logic [D-1:0] hist, input bit spk);
        exp_wr.push_back({AW'(4*n+1), pot});
        exp_wr.push_back({AW'(4*n+3), hist});
        if (spk) exp_spk.push_back(NW'(n));
    endtask

    task automatic table1();
        set_n(0, 16'd1,    16'd3,    16'd100,  16'h0007, 16'd2);
        set_n(1, 16'h0100, 16'h7FF0, 16'h7FFF, 16'h0003, 16'h0100);
        set_n(2, 16'd5,    16'd10,   16'd15,   16'h0009, 16'd0);
        set_n(3, 16'hFF00, 16'h8010, 16'h0000, 16'h00FF, 16'd0);
    endtask

    task automatic run_sweep(input bit poke);
        int s, d0;
        @(negedge clk_i);
        start_i = 1'b1;
        s  = cyc;
        d0 = done_cnt;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_after_start", busy_o, 1);
        if (poke) begin
            repeat (6) @(negedge clk_i);
            start_i = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
        end
        for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge clk_i);
        chk("done_latency", done_cyc - s, 33);
        chk("busy_at_done", busy_o, 0);
        repeat (40) @(negedge clk_i);
        chk("done_once", done_cnt - d0, 1);
        chk("wr_drained", exp_wr.size(), 0);
        chk("spk_drained", exp_spk.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every write/spike and tracks the read sequence.
    initial begin
        logic [AW+D-1:0] e;
        int rn, rs;
        rn = 0;
        rs = 0;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                chk("rd_wr_excl", stat_rd_en_o & stat_wr_en_o, 0);
                if (stat_rd_en_o) begin
                    chk("rd_addr", stat_rd_addr_o, {rn[NW-1:0], rs[1:0]});
                    if (rs == 0) chk("curr_addr", {curr_rd_en_o, curr_addr_o}, {1'b1, rn[NW-1:0]});
                    rs++;
                    if (rs == 4) begin
                        rs = 0;
                        rn++;
                    end
                end
                if (stat_wr_en_o) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", stat_wr_addr_o, stat_wr_data_o);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", stat_wr_addr_o, e[AW+D-1:D]);
                        chk("wr_data", stat_wr_data_o, e[D-1:0]);
                    end
                end
                if (spike_vld_o) begin
                    if (exp_spk.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spike_unexpected: got neuron %0d expected no spike", spike_nurn_o);
                    end else chk("spike_nurn", spike_nurn_o, exp_spk.pop_front());
                end
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                    rn = 0;
                    rs = 0;
                end
            end else begin
                rn = 0;
                rs = 0;
            end
        end
    end

    initial begin
        int d0;
        repeat (3) @(negedge clk_i);
        chk_rst("reset");
        rst_n_i = 1'b1;

        table1();
        do_load();
        exp_n(0, 16'd6, 16'd8, 0);
        exp_n(1, LEAK ? 16'h79F1 : 16'h0000, LEAK ? 16'd4 : 16'd0, !LEAK);
        exp_n(2, 16'd0, 16'd0, 1);
        exp_n(3, LEAK ? 16'h870F : 16'h8000, 16'h00FF, 0);
        run_sweep(0);
        chk("wr_addr_hold", stat_wr_addr_o, 4'hF);
        chk("wr_data_hold", stat_wr_data_o, 16'h00FF);
        chk("rd_addr_hold", stat_rd_addr_o, 4'hF);

        set_n(0, 16'd0,    16'd160,  16'd1000, 16'h0000, 16'd0);
        set_n(1, 16'hFFFD, 16'hFFFB, 16'hFFF6, 16'h0020, 16'hFFFE);
        set_n(2, 16'd0,    16'd100,  16'd51,   16'h12FE, 16'hFFCE);
        set_n(3, 16'h7FFF, 16'h0000, 16'h7FFF, 16'hAB10, 16'h7FFF);
        do_load();
        exp_n(0, LEAK ? 16'd150 : 16'd160, 16'd1, 0);
        exp_n(1, 16'd0, 16'd0, 1);
        exp_n(2, LEAK ? 16'h002C : 16'h0032, 16'h00FF, 0);
        exp_n(3, 16'd0, 16'd0, 1);
        run_sweep(1);

        table1();
        do_load();
        post = init_mem;
        post[1] = 16'd6;
        post[3] = 16'd8;
        exp_n(0, 16'd6, 16'd8, 0);
        exp_wr.push_back({AW'(5), LEAK ? 16'h79F1 : 16'h0000});
        if (!LEAK) exp_spk.push_back(NW'(1));
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 40 && !(stat_wr_en_o && stat_wr_addr_o == AW'(5)); i++) @(negedge clk_i);
        chk("reached_wp1", {stat_wr_en_o, stat_wr_addr_o}, {1'b1, AW'(5)});
        #1 rst_n_i = 1'b0;
        #1 chk_rst("abort");
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (40) @(negedge clk_i);
        chk("no_done_after_abort", done_cnt - d0, 0);
        chk("idle_after_abort", busy_o, 0);
        for (int a = 0; a < 16; a++) chk($sformatf("mem_after_abort[%0d]", a), mem[a], post[a]);
        chk("abort_wr_drained", exp_wr.size(), 0);
        chk("abort_spk_drained", exp_spk.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
